// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding, requester indices and ASCII constants
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_e;
  localparam int REQ_MORSE = 0;
  localparam int REQ_MANUAL = 1;
  localparam int REQ_STATUS = 2;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;
endpackage

// File: rtl/uart_tx_arbiter_sync_fifo.sv
// uart_tx_arbiter_sync_fifo: 8-bit sync FIFO; push/din in, pop/dout (show-ahead head) out, full/empty/level status
module uart_tx_arbiter_sync_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin req_valid/req_data/req_ready sources -> FIFO -> uart_tx (char_to_send_out, send_trigger_out, uart_busy_in); fifo_level, timeout_pulse status
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int BUSY_TIMEOUT = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = BUSY_TIMEOUT > 2 ? $clog2(BUSY_TIMEOUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 uart_busy_in,
  output logic [7:0]           char_to_send_out,
  output logic                 send_trigger_out,
  output logic [LW-1:0]        fifo_level,
  output logic                 timeout_pulse
);
  tx_state_e state, state_nxt;
  logic [7:0] req_arr [NUM_REQ];
  logic [7:0] head;
  logic [IW-1:0] rr_ptr, gnt_idx, idx;
  logic [IW:0] sum;
  logic [CW-1:0] cnt, cnt_nxt;
  logic gnt_found, accept, full, empty, pop, timeout_nxt;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_arr[g] = req_data[8*g +: 8];
  end
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign accept = rst_n && gnt_found && !full;
  assign req_ready = accept ? NUM_REQ'(1) << gnt_idx : '0;
  uart_tx_arbiter_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept),
    .pop(pop),
    .din(req_arr[gnt_idx]),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    pop = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty && !uart_busy_in;
        state_nxt = pop ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        cnt_nxt = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        timeout_nxt = !uart_busy_in && cnt == CW'(BUSY_TIMEOUT - 1);
        cnt_nxt = uart_busy_in || timeout_nxt ? cnt : cnt + 1'b1;
        state_nxt = uart_busy_in ? WAIT_DONE : timeout_nxt ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: state_nxt = uart_busy_in ? WAIT_DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= '0;
      char_to_send_out <= '0;
      send_trigger_out <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rr_ptr <= accept ? (gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : rr_ptr;
      char_to_send_out <= pop ? head : char_to_send_out;
      send_trigger_out <= state == LAUNCH;
      timeout_pulse <= timeout_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with round-robin reference model and UART busy model
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;
  localparam int NR = 3;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic uart_busy_in = 1'b0;
  logic [7:0] char_to_send_out;
  logic send_trigger_out;
  logic [3:0] fifo_level;
  logic timeout_pulse;
  uart_tx_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_busy_in(uart_busy_in),
    .char_to_send_out(char_to_send_out),
    .send_trigger_out(send_trigger_out),
    .fifo_level(fifo_level),
    .timeout_pulse(timeout_pulse)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int acc = 0, trig = 0, mrr = 0, n_sent = 0, n_to = 0, to_cnt = 0;
  int frame = 0, frame_len = 4, uart_mode = 0, cyc = 0;
  int last_trig_cyc = 0, last_acc_cyc = 0;
  logic force_busy = 1'b0;
  logic [7:0] src_q [NR][$];
  logic [7:0] exp_q [$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = src_q[i].size() > 0;
      req_data[8*i +: 8] = src_q[i].size() > 0 ? src_q[i][0] : 8'h00;
    end
  endtask
  task automatic push_src(input int s, input logic [7:0] c);
    src_q[s].push_back(c);
    drive();
  endtask
  task automatic cycle();
    int w, g, cn;
    logic [NR-1:0] got, exp_oh;
    logic live;
    @(negedge clk);
    cn = cyc;
    live = rst_n;
    got = req_ready;
    w = -1;
    for (int k = 0; k < NR; k++) if (w < 0 && req_valid[(mrr + k) % NR]) w = (mrr + k) % NR;
    if (live) begin
      exp_oh = w < 0 ? '0 : NR'(1) << w;
      if (w < 0 || acc - trig < DEPTH) chk("grant", 32'(got), 32'(exp_oh));
      else chk("grant_when_full", 32'(got == '0 || got == exp_oh), 1);
    end
    @(posedge clk);
    #1;
    g = -1;
    for (int k = NR - 1; k >= 0; k--) if (got[k]) g = k;
    if (live && g >= 0 && src_q[g].size() > 0) begin
      exp_q.push_back(src_q[g].pop_front());
      acc++;
      mrr = (g + 1) % NR;
      last_acc_cyc = cn;
    end
    drive();
  endtask
  task automatic wait_drain(input int budget, input int tail);
    int b = 0;
    while (b < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                           exp_q.size() == 0 && frame == 0 && !uart_busy_in)) begin
      cycle();
      b++;
    end
    chk("drain_in_budget", 32'(b < budget), 1);
    repeat (tail) cycle();
    chk("level_after_drain", 32'(fifo_level), 0);
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cycle();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_trigger", 32'(send_trigger_out), 0);
    chk("rst_timeout", 32'(timeout_pulse), 0);
    chk("rst_char", 32'(char_to_send_out), 0);
    chk("rst_ready", 32'(req_ready), 0);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    acc = 0;
    trig = 0;
    mrr = 0;
    to_cnt = 0;
    drive();
    rst_n = 1'b1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (send_trigger_out && rst_n) chk("send_while_busy", 32'(uart_busy_in), 0);
      if (send_trigger_out && uart_mode == 0) frame = frame_len;
      else if (frame > 0) frame--;
      uart_busy_in = force_busy || frame > 0;
    end
  end
  initial begin
    logic exp_to;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_to = to_cnt == 1;
        if (timeout_pulse || exp_to) chk("timeout_pulse", 32'(timeout_pulse), 32'(exp_to));
        if (to_cnt > 0) to_cnt--;
        if (timeout_pulse) n_to++;
        if (send_trigger_out) begin
          n_sent++;
          trig++;
          last_trig_cyc = cyc;
          if (exp_q.size() == 0) chk("unexpected_send", 32'(char_to_send_out), 32'hFFFF_FFFF);
          else chk("send_char", 32'(char_to_send_out), 32'(exp_q.pop_front()));
          if (uart_mode == 1) to_cnt = 4;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    int base;
    int b;
    src_q[1].push_back(8'h78);
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset(3);
    push_src(0, 8'h45);
    wait_drain(50, 3);
    chk("latency_accept_to_send", 32'(last_trig_cyc - last_acc_cyc), 3);
    chk("single_sent", 32'(n_sent), 1);
    do_reset(2);
    push_src(0, 8'h41);
    push_src(1, 8'h42);
    push_src(2, 8'h43);
    wait_drain(100, 3);
    for (int i = 0; i < 6; i++) src_q[0].push_back(8'h61 + 8'(i));
    for (int i = 0; i < 3; i++) src_q[1].push_back(8'h31 + 8'(i));
    for (int i = 0; i < 3; i++) src_q[2].push_back(8'h78 + 8'(i));
    drive();
    wait_drain(300, 3);
    force_busy = 1'b1;
    repeat (2) cycle();
    for (int i = 0; i < 9; i++) src_q[i % NR].push_back(8'h50 + 8'(i));
    drive();
    repeat (12) cycle();
    chk("full_level", 32'(fifo_level), 8);
    chk("full_ready", 32'(req_ready), 0);
    chk("ninth_pending", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size()), 1);
    base = n_sent;
    force_busy = 1'b0;
    wait_drain(300, 3);
    chk("all_nine_sent", 32'(n_sent - base), 9);
    uart_mode = 1;
    base = n_to;
    push_src(1, 8'h54);
    push_src(2, 8'h55);
    wait_drain(100, 8);
    chk("timeouts_seen", 32'(n_to - base), 2);
    uart_mode = 0;
    frame_len = 20;
    base = n_sent;
    for (int i = 0; i < 4; i++) src_q[0].push_back(8'h57 + 8'(i));
    drive();
    b = 0;
    while (n_sent == base && b < 30) begin
      cycle();
      b++;
    end
    chk("first_send_seen", 32'(b < 30), 1);
    repeat (4) cycle();
    chk("queued_three", 32'(fifo_level), 3);
    push_src(1, 8'h71);
    do_reset(2);
    chk("busy_after_reset", 32'(uart_busy_in), 1);
    base = n_sent;
    push_src(2, 8'h4E);
    b = 0;
    while (uart_busy_in && b < 40) begin
      cycle();
      b++;
    end
    chk("no_send_while_busy", 32'(n_sent - base), 0);
    wait_drain(50, 3);
    chk("post_reset_sent", 32'(n_sent - base), 1);
    for (int r = 0; r < 6; r++) begin
      frame_len = $urandom_range(2, 8);
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 2) == 0) push_src($urandom_range(0, NR - 1), 8'($urandom_range(32, 126)));
        cycle();
      end
      wait_drain(600, 3);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
